// File: rtl/rpi_irq_handshake.sv
// rpi_irq_handshake: arms an interrupt when the sample FIFO fills, then paces
// FIFO pops from the Pi's asynchronous read strobe until the burst ends or stalls.
module rpi_irq_handshake #(
    parameter int LEVEL_W     = 10,
    parameter int THRESHOLD   = 256,
    parameter int BURST       = 256,
    parameter int TIMEOUT_CYC = 131072,
    parameter int HOLDOFF_CYC = 64
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic [LEVEL_W-1:0] fifo_level,
    input  logic               rpi_rd_clk,
    input  logic               err_clear,
    output logic               interrupt_enable,
    output logic               fifo_rd_en,
    output logic [8:0]         words_left,
    output logic               timeout_err,
    output logic               underrun_err,
    output logic               busy
);
    localparam int HW = $clog2(HOLDOFF_CYC + 1);

    typedef enum logic [1:0] {IDLE, ARMED, XFER, HOLDOFF} state_t;

    state_t        state;
    logic [2:0]    rd_sync;
    logic          rd_edge;
    logic [16:0]   to_cnt;
    logic [HW-1:0] hold_cnt;

    // rd_sync[1:0] is the synchronizer, rd_sync[2] the edge-detect flop;
    // rd_edge retimes the detected edge so the pop lands on the 4th sampling clock.
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state            <= IDLE;
            rd_sync          <= '0;
            rd_edge          <= 1'b0;
            to_cnt           <= '0;
            hold_cnt         <= '0;
            interrupt_enable <= 1'b0;
            fifo_rd_en       <= 1'b0;
            words_left       <= '0;
            timeout_err      <= 1'b0;
            underrun_err     <= 1'b0;
            busy             <= 1'b0;
        end else begin
            rd_sync    <= {rd_sync[1:0], rpi_rd_clk};
            rd_edge    <= rd_sync[1] & ~rd_sync[2];
            fifo_rd_en <= 1'b0;
            if (err_clear) begin
                timeout_err  <= 1'b0;
                underrun_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (fifo_level >= LEVEL_W'(THRESHOLD)) begin
                        state            <= ARMED;
                        interrupt_enable <= 1'b1;
                        words_left       <= 9'(BURST);
                        to_cnt           <= '0;
                        busy             <= 1'b1;
                    end
                end
                ARMED, XFER: begin
                    // a read edge takes priority over a coincident timeout
                    if (rd_edge) begin
                        words_left <= words_left - 9'(words_left != '0);
                        to_cnt     <= '0;
                        if (fifo_level != '0) fifo_rd_en <= 1'b1;
                        else underrun_err <= 1'b1;
                        if (words_left <= 9'd1) begin
                            state            <= HOLDOFF;
                            interrupt_enable <= 1'b0;
                            hold_cnt         <= '0;
                        end else begin
                            state <= XFER;
                        end
                    end else if (to_cnt == 17'(TIMEOUT_CYC - 1)) begin
                        timeout_err      <= 1'b1;
                        interrupt_enable <= 1'b0;
                        words_left       <= '0;
                        state            <= HOLDOFF;
                        hold_cnt         <= '0;
                    end else if (to_cnt != '1) begin
                        to_cnt <= to_cnt + 17'd1;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt == HW'(HOLDOFF_CYC - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rpi_irq_handshake.md
RPI_IRQ_HANDSHAKE -- requirements
Module: rpi_irq_handshake

Interface
REQ-001 Parameters SHALL be (name, default, meaning): LEVEL_W, 10, FIFO level width.
REQ-002 THRESHOLD SHALL default to 256: the FIFO level that arms an interrupt.
REQ-003 BURST SHALL default to 256: the number of words the Pi reads per interrupt.
REQ-004 TIMEOUT_CYC SHALL default to 131072: the maximum clk_in cycles between Pi reads.
REQ-005 HOLDOFF_CYC SHALL default to 64: the minimum idle cycles between bursts.
REQ-006 Port clk_in SHALL be input, 1 bit: the 50 MHz system clock; the design has one clock.
REQ-007 Port reset SHALL be input, 1 bit: asynchronous, active-high reset.
REQ-008 Port fifo_level SHALL be input, LEVEL_W bits: the sample FIFO occupancy, synchronous to clk_in.
REQ-009 Port rpi_rd_clk SHALL be input, 1 bit: the Pi read strobe, asynchronous to clk_in; each rising edge is one word read.
REQ-010 Port err_clear SHALL be input, 1 bit: a synchronous pulse that clears sticky errors.
REQ-011 Port interrupt_enable SHALL be output, 1 bit: the interrupt request to the Pi interrupt-clock generator.
REQ-012 Port fifo_rd_en SHALL be output, 1 bit: a one-cycle FIFO pop.
REQ-013 Port words_left SHALL be output, 9 bits: the words remaining in the current burst.
REQ-014 Port timeout_err SHALL be output, 1 bit: sticky; the Pi stopped reading mid-burst.
REQ-015 Port underrun_err SHALL be output, 1 bit: sticky; the Pi read while the FIFO was empty.
REQ-016 Port busy SHALL be output, 1 bit: high in every state except IDLE.

Function
REQ-017 rpi_rd_clk SHALL pass through a 2-flop synchronizer plus a third edge-detect flop; an edge is detected when sync2=1 and sync3=0.
REQ-018 fifo_rd_en SHALL be registered, high for exactly one cycle, on the 4th clk_in rising edge after the first edge that samples rpi_rd_clk high.
REQ-019 The FSM SHALL have exactly four states: IDLE, ARMED, XFER, HOLDOFF.
REQ-020 IDLE -> ARMED SHALL occur when fifo_level >= THRESHOLD; on entry, interrupt_enable=1 and words_left=BURST.
REQ-021 ARMED -> XFER SHALL occur on the first detected edge; that edge SHALL be counted as a read.
REQ-022 In ARMED and XFER, every detected edge SHALL decrement words_left by 1.
REQ-023 In ARMED and XFER, every detected edge SHALL pulse fifo_rd_en only when fifo_level != 0; otherwise underrun_err SHALL be set and the count still decremented.
REQ-024 When words_left goes 1 -> 0, the FSM SHALL go to HOLDOFF and interrupt_enable SHALL drop on the same edge that writes 0.
REQ-025 A timeout counter SHALL reset on entry to ARMED and on every detected edge, and increment each cycle while in ARMED or XFER.
REQ-026 When the timeout counter reaches TIMEOUT_CYC-1, timeout_err SHALL be set, interrupt_enable cleared, words_left cleared, and the FSM SHALL go to HOLDOFF.
REQ-027 If an edge and a timeout occur in the same cycle, the edge SHALL win and no timeout SHALL be taken.
REQ-028 HOLDOFF SHALL last exactly HOLDOFF_CYC cycles and then go to IDLE; detected edges in HOLDOFF or IDLE SHALL be ignored (no fifo_rd_en, no count change).
REQ-029 err_clear SHALL clear both sticky errors; if err_clear coincides with a new error event, the error SHALL win (flag stays 1).
REQ-030 IDLE re-arms only when the level test of REQ-020 holds; a level already >= THRESHOLD at the end of HOLDOFF SHALL re-arm on the next cycle.
REQ-031 words_left SHALL never wrap below 0.
REQ-032 The timeout counter SHALL be 17 bits and saturate, never wrap.

Reset
REQ-033 While reset=1, all outputs SHALL be 0, the FSM SHALL be in IDLE, and all counters and synchronizer flops SHALL be 0, asynchronously and without waiting for clk_in.
REQ-034 Reset mid-burst SHALL drop interrupt_enable immediately; after release, a burst SHALL start only via IDLE -> ARMED.
REQ-035 After reset release, the first detected edge SHALL be no earlier than the 3rd clk_in edge.

Verification
REQ-036 Scenario: fifo_level=300, then 256 Pi edges spaced 20 cycles -> interrupt_enable rises 1 cycle after the level is applied; 256 fifo_rd_en pulses; words_left reaches 0; interrupt_enable falls; busy stays high for 64 more cycles.
REQ-037 Scenario: fifo_level=300, 10 edges, then silence -> timeout_err=1 exactly 131072 cycles after the 10th detected edge; interrupt_enable=0; words_left=0.
REQ-038 Scenario: fifo_level=0 during XFER, one edge -> no fifo_rd_en; underrun_err=1; words_left decrements by 1.
REQ-039 Scenario: edge detected on the timeout-limit cycle -> no timeout_err; the counter restarts.
REQ-040 Scenario: reset asserted mid-XFER with words_left=100 -> all outputs 0 before the next clk_in edge; no burst starts until fifo_level >= 256 after release.
REQ-041 Scenario: err_clear pulsed while timeout_err=1 and no new error -> timeout_err=0 next cycle; err_clear coincident with an underrun edge -> underrun_err stays 1.
